// File: rtl/instr_sequencer.sv
// instr_sequencer: queues (FUNCTION, Data) pairs from a host and issues them
// one at a time to the register/ALU core. Each issue is a one-cycle W strobe.
// FUNCTION and Data then stay stable until the core raises Finish. A watchdog
// flags a core that never reports Finish.
module instr_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_func,
  input  logic [7:0] in_data,
  input  logic       run,
  input  logic       err_clr,
  output logic [6:0] FUNCTION,
  output logic [7:0] Data,
  output logic       W,
  input  logic       Finish,
  output logic       busy,
  output logic       empty,
  output logic       full,
  output logic       timeout_err,
  output logic [7:0] issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t          r_state, w_next;
  logic [14:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic [CW-1:0]   r_wdog;
  logic [6:0]      r_func;
  logic [7:0]      r_data;
  logic            r_w;
  logic            r_err;
  logic [7:0]      r_issued;

  logic            w_push, w_start, w_fin, w_tmo;
  logic            w_empty, w_full;
  logic [14:0]     w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rptr];

  assign in_ready     = !w_full;
  assign empty        = w_empty;
  assign full         = w_full;
  assign busy         = (r_state != S_IDLE);
  assign FUNCTION     = r_func;
  assign Data         = r_data;
  assign W            = r_w;
  assign timeout_err  = r_err;
  assign issued_count = r_issued;

  // Next-state decode; the issue decision is the only source of a pop.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_fin   = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run && !w_empty && !r_err) begin
          w_next  = S_ISSUE;
          w_start = 1'b1;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        // Finish takes priority over a watchdog expiring in the same cycle.
        if (Finish) begin
          w_fin  = 1'b1;
          w_next = S_GAP;
        end else if (r_wdog == CW'(TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Queue storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_func, in_data};
  end

  // Queue pointers and occupancy; a push and a pop together leave the count unchanged.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + AW'(1);
      if (w_start) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_start);
    end
  end

  // Issue outputs: load on the ISSUE entry edge only, W is a single-cycle strobe.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_func <= '0;
      r_data <= '0;
      r_w    <= 1'b0;
    end else begin
      r_w <= w_start;
      if (w_start) {r_func, r_data} <= w_head;
    end
  end

  // Watchdog counter: cleared leaving ISSUE, counts every WAIT cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                    r_wdog <= '0;
    else if (r_state == S_ISSUE)   r_wdog <= '0;
    else if (r_state == S_WAIT)    r_wdog <= r_wdog + CW'(1);
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)       r_err <= 1'b0;
    else if (w_tmo)   r_err <= 1'b1;
    else if (err_clr) r_err <= 1'b0;
  end

  // Completion counter, wraps modulo 256.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)     r_issued <= '0;
    else if (w_fin) r_issued <= r_issued + 8'd1;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream feeder for the 8-bit register/ALU datapath core.
- Buffers a queue of (FUNCTION, Data) instruction pairs pushed by a host or test harness.
- Issues one pair at a time to the core as a W pulse, then holds FUNCTION/Data stable until the core raises Finish.
- A watchdog flags a core that never reports Finish.

Parameters:
- DEPTH, 8, queue entries; power of 2, minimum 2.
- TIMEOUT, 64, maximum cycles spent in WAIT before the watchdog fires; minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- in_valid  input  1  host offers an entry.
- in_ready  output  1  queue can accept; equals !full.
- in_func  input  7  FUNCTION word of the offered entry.
- in_data  input  8  Data byte of the offered entry.
- run  input  1  issue enable; when low, no new issue starts.
- err_clr  input  1  synchronous clear of timeout_err.
- FUNCTION  output  7  instruction to the core; registered.
- Data  output  8  external data to the core; registered.
- W  output  1  one-cycle start strobe to the core; registered.
- Finish  input  1  core completion, level.
- busy  output  1  high in ISSUE, WAIT and GAP.
- empty  output  1  queue count == 0.
- full  output  1  queue count == DEPTH.
- timeout_err  output  1  sticky watchdog flag.
- issued_count  output  8  number of instructions completed with Finish; wraps modulo 256.

Behaviour:
- Reset (clr_n low, asynchronous):
  - queue empty, read/write pointers 0.
  - FSM in IDLE.
  - FUNCTION=0, Data=0, W=0, timeout_err=0, issued_count=0.
  - busy=0, empty=1, full=0.
- Queue:
  - Circular buffer, 15-bit entries {func, data}, log2(DEPTH)+1-bit count.
  - Push occurs when in_valid && in_ready at a rising edge.
  - Pop occurs only on the ISSUE entry edge.
  - Simultaneous push and pop: count unchanged, both pointers advance. Legal when full, but in_ready is already 0, so no push happens.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE: if run && !empty && !timeout_err, at the next edge go to ISSUE. On that same edge, load FUNCTION/Data from the queue head, pop it, and set W=1.
  - ISSUE: one cycle. W=1. Finish is ignored. Next edge: W=0, clear the watchdog counter, go to WAIT.
  - WAIT: FUNCTION/Data held. The watchdog counter increments each cycle.
    - If Finish=1: issued_count+1, go to GAP.
    - Else if counter == TIMEOUT-1: set timeout_err, go to IDLE.
    - Finish and timeout in the same cycle: Finish wins.
  - GAP: one cycle with W=0 so the core can return to idle. Then go to IDLE.
- FUNCTION/Data keep their last issued value in IDLE and GAP; they change only on the ISSUE entry edge.
- Latency: with the FSM in IDLE, run=1 and the queue empty, a push accepted at edge k makes W high between edges k+1 and k+2.
- Back-to-back issue: minimum spacing between W pulses is Finish latency + 3 cycles (ISSUE, ≥1 WAIT, GAP, IDLE).
- run deasserted mid-instruction: the current instruction completes normally; the FSM then stops in IDLE.
- timeout_err:
  - Blocks further issue until err_clr=1 at an edge or reset.
  - The queue contents are preserved; the timed-out entry is not re-queued.
  - err_clr and a new timeout in the same cycle: set wins.
- Reset mid-operation: everything returns to reset values immediately. Queued entries are discarded.
- W never asserts for two consecutive cycles.

Test Plan:
- Reset then push {func=7'h12, data=8'hA5} with run=1: W high exactly one cycle, two edges after the push; FUNCTION=12h and Data=A5h held. Finish pulsed 3 cycles later gives issued_count=1, busy=0 after GAP, empty=1.
- Push 8 entries with run=0: full=1, in_ready=0, and a 9th push is ignored. Set run=1 with Finish auto-asserted 2 cycles after each W: 8 W pulses in FIFO order, issued_count=8, and the 9th value never appears.
- Finish held low with TIMEOUT=64: timeout_err=1 after 64 WAIT cycles, FSM in IDLE, remaining entries not issued. err_clr=1 resumes issue of the next entry.
- Finish pulsed during the ISSUE cycle only: it is ignored, and the FSM stays in WAIT until a later Finish.
- Push on the same edge as a pop with count=3: count stays 3 and pointer wrap is correct over 20 instructions. issued_count wraps 255→0 after 256 completions.
- clr_n low during WAIT with 4 entries queued: W=0, FUNCTION=0, empty=1, busy=0 immediately, and no issue after release.
